row_buffer_5px: RTL and testbench

- Single-row pixel line buffer for the Gaussian blur front end; blur_control instantiates six copies and rotates writes and reads across them.
- Stores one row of 8-bit pixels, written sequentially with a wrapping write pointer.
- Reads the row back sequentially with an independent wrapping read pointer.
- Presents the last 5 pixels read as a 40-bit horizontal tap window for the 5x5 convolution.

---
 rtl/blur_pkg.sv | 13 +
 rtl/row_buffer_5px_if.sv | 29 ++
 rtl/row_buffer_ram.sv | 45 ++++
 rtl/row_buffer_5px.sv | 110 +++++++++++
 tb/tb_row_buffer_5px.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/blur_pkg.sv
// Shared definitions for the Gaussian blur front end: pixel geometry,
// kernel size and the pixel / tap-window types used by the line buffers.
package blur_pkg;

    localparam int PIX_W       = 8;
    localparam int ROW_DEPTH   = 645;
    localparam int ROW_ADDR_W  = $clog2(ROW_DEPTH);
    localparam int KERNEL_TAPS = 5;

    typedef logic [PIX_W-1:0]             pixel_t;
    typedef logic [PIX_W*KERNEL_TAPS-1:0] tap_window_t;

endpackage : blur_pkg

// File: rtl/row_buffer_5px_if.sv
// Pixel stream interface of one row buffer: write data/strobe, read strobe
// and the returned horizontal tap window.
interface row_buffer_5px_if #(
    parameter int DATA_W = blur_pkg::PIX_W,
    parameter int TAPS   = blur_pkg::KERNEL_TAPS
);

    logic [DATA_W-1:0]      data;
    logic                   write_en;
    logic                   read_en;
    logic [DATA_W*TAPS-1:0] extended_data;

    // Controller side: drives pixels and strobes, receives the window.
    modport master (
        output data,
        output write_en,
        output read_en,
        input  extended_data
    );

    // Buffer side: accepts pixels and strobes, returns the window.
    modport slave (
        input  data,
        input  write_en,
        input  read_en,
        output extended_data
    );

endinterface : row_buffer_5px_if

// File: rtl/row_buffer_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read and a write to the same address in one cycle return the old
// contents. The read register has a synchronous clear; the array is
// never cleared so it maps onto a single block RAM.
module row_buffer_ram
    import blur_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int DEPTH  = ROW_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Write port: store the incoming pixel at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: registered read of the old contents, clearable to zero.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule : row_buffer_ram

// File: rtl/row_buffer_5px.sv
// Single-row pixel line buffer with a 5-pixel horizontal tap window.
// Writes and reads walk independent pointers that wrap at DEPTH-1.
// The newest window pixel is the RAM read register itself, so a read
// strobe shows its pixel in [DATA_W-1:0] one edge later; the older taps
// are a shift register fed from that read register.
// Build option: define ROW_BUFFER_FLUSH_TAPS_EN to zero the older taps on
// every read of column 0 so no pixel from the previous row leaks into
// the window.
module row_buffer_5px
    import blur_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int DEPTH  = ROW_DEPTH,
    parameter int TAPS   = KERNEL_TAPS,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    row_buffer_5px_if.slave   bus
);

    localparam int                TAIL_W    = DATA_W * (TAPS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_nxt_s;
    logic [ADDR_W-1:0] rd_ptr_nxt_s;
    logic              row_start_s;
    logic              ram_wr_en_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [TAIL_W-1:0] tail_r;

    // Next pointer values with wrap at the last column.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1);
        rd_ptr_nxt_s = rd_ptr_r + ADDR_W'(1);
        if (wr_ptr_r == LAST_ADDR) begin
            wr_ptr_nxt_s = '0;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1);
        end
        if (rd_ptr_r == LAST_ADDR) begin
            rd_ptr_nxt_s = '0;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r + ADDR_W'(1);
        end
    end

    // Row-start detection for the optional tap flush; reset blocks RAM writes.
    always_comb begin
        row_start_s = 1'b0;
`ifdef ROW_BUFFER_FLUSH_TAPS_EN
        row_start_s = (rd_ptr_r == '0);
`else
        row_start_s = 1'b0;
`endif
        ram_wr_en_s = bus.write_en & ~reset;
    end

    // Pointer registers; reset wins over both strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (bus.write_en) begin
                wr_ptr_r <= wr_ptr_nxt_s;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (bus.read_en) begin
                rd_ptr_r <= rd_ptr_nxt_s;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Older taps: shift the current newest pixel in on each read.
    always_ff @(posedge clk) begin
        if (reset) begin
            tail_r <= '0;
        end else if (bus.read_en && row_start_s) begin
            tail_r <= '0;
        end else if (bus.read_en) begin
            tail_r <= {tail_r[TAIL_W-DATA_W-1:0], rd_data_s};
        end else begin
            tail_r <= tail_r;
        end
    end

    row_buffer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (bus.data),
        .rd_en   (bus.read_en),
        .rd_clr  (reset),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    assign bus.extended_data = {tail_r, rd_data_s};

endmodule : row_buffer_5px

// File: tb/tb_row_buffer_5px.sv
// Self-checking bench for row_buffer_5px. Every cycle the stimulus task
// updates a plain array/pointer model of the row buffer and queues the
// window it should show after the edge; a monitor compares the DUT
// window against the queue one time unit after each rising edge.
module tb_row_buffer_5px;
    import blur_pkg::*;

    localparam int DEPTH = ROW_DEPTH;

    logic clk;
    logic reset;

    row_buffer_5px_if bus ();

    row_buffer_5px dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    pixel_t      mem_m [DEPTH];
    int          wr_m;
    int          rd_m;
    tap_window_t win_m;
    tap_window_t exp_q [$];

    task automatic compare(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the reference-model update.
    task automatic step(input logic rst, input logic we, input logic re, input pixel_t d);
        pixel_t px;
        @(negedge clk);
        reset        = rst;
        bus.write_en = we;
        bus.read_en  = re;
        bus.data     = d;
        if (rst) begin
            wr_m  = 0;
            rd_m  = 0;
            win_m = '0;
        end else begin
            if (re) begin
                px = mem_m[rd_m];
`ifdef ROW_BUFFER_FLUSH_TAPS_EN
                if (rd_m == 0) win_m = '0;
`endif
                win_m = {win_m[31:0], px};
                rd_m  = (rd_m + 1) % DEPTH;
            end
            if (we) begin
                mem_m[wr_m] = d;
                wr_m = (wr_m + 1) % DEPTH;
            end
        end
        exp_q.push_back(win_m);
    endtask

    // Directed check of the whole window right after the pending edge.
    task automatic check_win(input string name, input logic [39:0] exp);
        @(posedge clk);
        #2;
        compare(name, bus.extended_data, exp);
    endtask

    // Directed check of the newest pixel right after the pending edge.
    task automatic check_low(input string name, input logic [7:0] exp);
        @(posedge clk);
        #2;
        compare(name, {32'd0, bus.extended_data[7:0]}, {32'd0, exp});
    endtask

    // Monitor: compare the DUT window against the queued expectation.
    initial begin
        tap_window_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compare("window", bus.extended_data, e);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        wr_m   = 0;
        rd_m   = 0;
        win_m  = '0;
        reset  = 1'b1;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.data     = 8'h00;

        // Reset window with strobes toggling.
        step(1'b1, 1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b0, 1'b1, 8'($urandom));
        check_win("reset_window", 40'h0);
        step(1'b0, 1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_win("first_rd_addr0", 40'h00_00_00_00_77);

        // Fill the row with column indices then read five.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        check_win("fill_read5", 40'h00_01_02_03_04);

        // Read three, hold four cycles, then one more read.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        check_win("hold", 40'h00_00_00_01_02);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_win("after_hold", 40'h00_00_01_02_03);

        // Both pointers wrap at the last column.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, (i == 0) ? 8'hA0 : 8'($urandom));
        step(1'b0, 1'b1, 1'b0, 8'h5A);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        check_low("ptr_wrap", 8'h5A);

        // Same-address read and write: read returns the old contents.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, (i == 7) ? 8'h11 : 8'($urandom));
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom));
        step(1'b0, 1'b1, 1'b1, 8'h22);
        check_low("collide_old", 8'h11);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        check_low("collide_new", 8'h22);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
        end

        // Reset in the middle of a row.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'hEE);
        check_win("midrow_reset", 40'h0);
        step(1'b0, 1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_win("midrow_restart", 40'h00_00_00_00_3C);

        // Row-start read after a full row of reads.
        for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
`ifdef ROW_BUFFER_FLUSH_TAPS_EN
        check_win("row_start_flush", 40'h00_00_00_00_3C);
`else
        check_low("row_start_carry", 8'h3C);
`endif

        step(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_row_buffer_5px
